hist_serializer: RTL and testbench

Consumer side of the per-cell orientation-histogram interface. Captures each 9-bin histogram presented as one wide word with a single-cycle `i_valid` pulse, buffers up to `DEPTH` histograms, and streams them out one bin per cycle over a valid/ready handshake toward block normalization. The producer has no backpressure, so loss is detected and flagged rather than prevented.

---
 rtl/hist_serializer_pkg.sv | 21 ++
 rtl/hist_serializer_if.sv | 27 ++
 rtl/hist_serializer_fifo.sv | 51 +++++
 rtl/hist_serializer.sv | 89 ++++++++
 tb/tb_hist_serializer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/hist_serializer_pkg.sv
// Shared HOG constants: bin count, index width, default bin width.
// Histograms pack bin 0 in the LSBs, bin NBIN-1 in the MSBs.
package hist_serializer_pkg;

  localparam int NBIN      = 9;
  localparam int BIN_IDX_W = 4;
  localparam int BIN_W_DEF = 20;

  localparam logic [BIN_IDX_W-1:0] LAST_IDX =
    BIN_IDX_W'(NBIN - 1);

  typedef enum logic {
    EMPTY,
    SEND
  } state_t;

  function automatic int bin_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/hist_serializer_if.sv
// Histogram capture strobe plus per-bin output stream.
// slave is the serializer view, master the producer/consumer view.
interface hist_serializer_if
  import hist_serializer_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF
);

  logic                      i_valid;
  logic [BIN_W*NBIN-1:0]     bin;
  logic                      o_valid;
  logic                      o_ready;
  logic [BIN_W-1:0]          o_data;
  logic [BIN_IDX_W-1:0]      o_idx;
  logic                      o_last;

  modport slave (
    input  i_valid, bin, o_ready,
    output o_valid, o_data, o_idx, o_last
  );

  modport master (
    output i_valid, bin, o_ready,
    input  o_valid, o_data, o_idx, o_last
  );

endinterface

// File: rtl/hist_serializer_fifo.sv
// Histogram FIFO: DEPTH wide entries, wrapping pointers, occupancy.
// Storage is intentionally not reset; only pointers and count are.
module hist_fifo #(
  parameter int W     = 180,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic         single
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata  = mem[rptr];
  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign single = (cnt == CW'(1));

endmodule

// File: rtl/hist_serializer.sv
// Buffers one-shot histograms and streams them out bin by bin.
// Input loss cannot be backpressured, so drops raise a sticky flag.
module hist_serializer
  import hist_serializer_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  hist_serializer_if.slave bus,
  output logic             overflow
);

  localparam int HW = BIN_W * NBIN;

  state_t               state;
  state_t               nxt;
  logic [BIN_IDX_W-1:0] idx;
  logic [HW-1:0]        head;
  logic                 hs;
  logic                 pop;
  logic                 push;
  logic                 full;
  logic                 empty;
  logic                 single;

  assign hs   = bus.o_valid && bus.o_ready;
  assign pop  = hs && (idx == LAST_IDX);
  // A full FIFO still takes a histogram when its head leaves this cycle.
  assign push = bus.i_valid && (!full || pop);

  hist_fifo #(
    .W     (HW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wdata  (bus.bin),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .single (single)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      EMPTY: if (push) nxt = SEND;
      SEND: begin
        if (empty)                        nxt = EMPTY;
        else if (pop && single && !push)  nxt = EMPTY;
      end
      default: nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)     idx <= '0;
      else if (hs) idx <= idx + BIN_IDX_W'(1);
      if (bus.i_valid && full && !pop) overflow <= 1'b1;
    end
  end

  always_comb begin
    bus.o_valid = (state == SEND);
    bus.o_data  = '0;
    if (bus.o_valid) begin
      for (int k = 0; k < NBIN; k++) begin
        if (idx == BIN_IDX_W'(k))
          bus.o_data = head[bin_lsb(k, BIN_W) +: BIN_W];
      end
    end
    bus.o_idx  = idx;
    bus.o_last = bus.o_valid && (idx == LAST_IDX);
  end

endmodule

// File: tb/tb_hist_serializer.sv
// Directed bench for hist_serializer: streaming, stalls,
// overflow, coincident push/pop and asynchronous reset.
module tb_hist_serializer;
  import hist_serializer_pkg::*;

  localparam int BW = 20;
  localparam int HW = BW * NBIN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ovf;
  int   checks = 0;
  int   errors = 0;

  hist_serializer_if #(.BIN_W(BW)) bus ();

  hist_serializer #(
    .BIN_W (BW),
    .DEPTH (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .overflow (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [HW-1:0] mk(input logic [BW-1:0] b);
    logic [HW-1:0] r;
    for (int k = 0; k < NBIN; k++) r[k*BW +: BW] = b + BW'(k);
    return r;
  endfunction

  function automatic logic [HW-1:0] rep(input logic [BW-1:0] v);
    logic [HW-1:0] r;
    for (int k = 0; k < NBIN; k++) r[k*BW +: BW] = v;
    return r;
  endfunction

  task automatic expect_bin(input string tag, input int k,
                            input logic [BW-1:0] d);
    check({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
    check({tag, "_idx"},   32'(bus.o_idx),   32'(k));
    check({tag, "_data"},  32'(bus.o_data),  32'(d));
    check({tag, "_last"},  32'(bus.o_last),  32'(k == 8));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
    check({tag, "_data"},  32'(bus.o_data),  32'd0);
    check({tag, "_idx"},   32'(bus.o_idx),   32'd0);
    check({tag, "_last"},  32'(bus.o_last),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    int n;
    logic [BW-1:0] base;

    bus.i_valid = 1'b0;
    bus.bin     = '0;
    bus.o_ready = 1'b0;

    // reset state
    cyc();
    expect_idle("rst");
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    // single histogram, bins 1..9
    cyc();
    bus.i_valid = 1'b1;
    bus.bin     = mk(20'd1);
    bus.o_ready = 1'b1;
    cyc();
    bus.i_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      expect_bin("single", k, BW'(k + 1));
      cyc();
    end
    expect_idle("single_end");

    // backpressure 1,0,0 pattern
    bus.i_valid = 1'b1;
    bus.bin     = mk(20'h100);
    bus.o_ready = 1'b0;
    cyc();
    bus.i_valid = 1'b0;
    e = 0;
    n = 0;
    while (e < 9 && n < 60) begin
      expect_bin("bp", e, 20'h100 + BW'(e));
      bus.o_ready = (n % 3 == 0);
      if (bus.o_ready) e++;
      n++;
      cyc();
    end
    check("bp_done", 32'(e), 32'd9);
    expect_idle("bp_end");

    // back-to-back A then B, no gap
    bus.o_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.bin     = rep(20'h00010);
    cyc();
    for (int j = 0; j < 18; j++) begin
      if (j == 0) bus.bin = rep(20'hFFFFF);
      if (j == 1) bus.i_valid = 1'b0;
      expect_bin("b2b", j % 9, (j < 9) ? 20'h00010 : 20'hFFFFF);
      cyc();
    end
    expect_idle("b2b_end");
    check("b2b_ovf", 32'(ovf), 32'd0);

    // full FIFO, push coincident with bin-8 pop
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.bin     = mk(20'h20);
    cyc();
    bus.bin     = mk(20'h40);
    cyc();
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    for (int j = 0; j < 27; j++) begin
      base = 20'h20 + BW'((j / 9) * 32);
      expect_bin("coin", j % 9, base + BW'(j % 9));
      bus.i_valid = (j == 8);
      bus.bin     = mk(20'h60);
      cyc();
    end
    expect_idle("coin_end");
    check("coin_ovf", 32'(ovf), 32'd0);

    // third histogram while stalled is dropped
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.bin     = mk(20'hA0);
    cyc();
    bus.bin     = mk(20'hB0);
    cyc();
    bus.bin     = mk(20'hC0);
    check("ovf_before", 32'(ovf), 32'd0);
    cyc();
    bus.i_valid = 1'b0;
    check("ovf_after", 32'(ovf), 32'd1);
    bus.o_ready = 1'b1;
    for (int j = 0; j < 18; j++) begin
      base = (j < 9) ? 20'hA0 : 20'hB0;
      expect_bin("ovf", j % 9, base + BW'(j % 9));
      cyc();
    end
    expect_idle("ovf_end");
    check("ovf_sticky", 32'(ovf), 32'd1);

    // async reset mid-stream with two entries queued
    bus.i_valid = 1'b1;
    bus.bin     = mk(20'h300);
    cyc();
    bus.bin     = mk(20'h400);
    for (int j = 0; j < 4; j++) begin
      expect_bin("pre_rst", j, 20'h300 + BW'(j));
      cyc();
      bus.i_valid = 1'b0;
    end
    expect_bin("pre_rst", 4, 20'h304);
    rst = 1'b1;
    #1;
    expect_idle("mid_rst");
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    cyc();
    rst = 1'b0;
    expect_idle("rst_hold");
    bus.i_valid = 1'b1;
    bus.bin     = mk(20'h500);
    cyc();
    bus.i_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      expect_bin("post_rst", k, 20'h500 + BW'(k));
      cyc();
    end
    expect_idle("post_rst_end");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
